// File: rtl/liteic_pkg.sv
// liteic_pkg: shared interconnect sizing, connectivity columns and arbiter state type
package liteic_pkg;

   localparam int IC_NUM_MASTER_SLOTS = 3;
   localparam int IC_NUM_SLAVE_SLOTS  = 2;

   // Row s holds the connectivity column of slave s: bit m set means master m reaches it.
   localparam logic [IC_NUM_SLAVE_SLOTS-1:0][IC_NUM_MASTER_SLOTS-1:0] IC_RD_CONN = '{3'b101, 3'b111};
   localparam logic [IC_NUM_SLAVE_SLOTS-1:0][IC_NUM_MASTER_SLOTS-1:0] IC_WR_CONN = '{3'b101, 3'b111};

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      RESP
   } arb_state_t;

   function automatic int idx_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/liteic_rr_picker.sv
// liteic_rr_picker: combinational round-robin search starting at ptr, ascending with wrap
module liteic_rr_picker
   import liteic_pkg::*;
#(
   parameter int N  = IC_NUM_MASTER_SLOTS,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [N-1:0] hi;
   logic [N-1:0] sel;

   // Requests at or above ptr take priority; otherwise the search has wrapped to the low end.
   always_comb begin
      hi  = req & ~((N'(1) << ptr) - N'(1));
      sel = (|hi) ? hi : req;
      gnt = '0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--)
         if (sel[i]) begin
            gnt    = '0;
            gnt[i] = 1'b1;
            idx    = IW'(i);
         end
   end

   assign any = |req;

endmodule

// File: rtl/liteic_slave_arbiter.sv
// liteic_slave_arbiter: round-robin owner of one slave channel, one outstanding transaction
module liteic_slave_arbiter
   import liteic_pkg::*;
#(
   parameter int                 NUM_MST   = IC_NUM_MASTER_SLOTS,
   parameter logic [NUM_MST-1:0] CONN_MASK = '1,
   localparam int                IW        = idx_w(NUM_MST)
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic [NUM_MST-1:0] reqst_val_i,
   output logic [NUM_MST-1:0] reqst_rdy_o,
   output logic [NUM_MST-1:0] grant_o,
   output logic [IW-1:0]      grant_idx_o,
   output logic               grant_vld_o,
   output logic               slv_reqst_val_o,
   input  logic               slv_reqst_rdy_i,
   input  logic               slv_resp_val_i,
   output logic               slv_resp_rdy_o,
   output logic [NUM_MST-1:0] resp_val_o,
   input  logic [NUM_MST-1:0] resp_rdy_i
);

   arb_state_t         state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d, idx_q, idx_d, pick_idx, ptr_nxt;
   logic [NUM_MST-1:0] gnt_q, gnt_d, pick_gnt, elig;
   logic               pick_any;

   assign elig    = reqst_val_i & CONN_MASK;
   assign ptr_nxt = (idx_q == IW'(NUM_MST - 1)) ? '0 : idx_q + 1'b1;

   liteic_rr_picker #(.N(NUM_MST), .IW(IW)) u_pick (
      .req (elig),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // The grant is one-hot, so masking with it selects the granted master's lane.
   always_comb begin
      state_d         = state_q;
      ptr_d           = ptr_q;
      gnt_d           = gnt_q;
      idx_d           = idx_q;
      slv_reqst_val_o = 1'b0;
      reqst_rdy_o     = '0;
      slv_resp_rdy_o  = 1'b0;
      resp_val_o      = '0;
      case (state_q)
         IDLE: if (pick_any) begin
            state_d = ADDR;
            gnt_d   = pick_gnt;
            idx_d   = pick_idx;
         end
         ADDR: begin
            slv_reqst_val_o = |(reqst_val_i & gnt_q);
            reqst_rdy_o     = slv_reqst_rdy_i ? gnt_q : '0;
            if (slv_reqst_val_o && slv_reqst_rdy_i) state_d = RESP;
         end
         RESP: begin
            slv_resp_rdy_o = |(resp_rdy_i & gnt_q);
            resp_val_o     = slv_resp_val_i ? gnt_q : '0;
            if (slv_resp_val_i && slv_resp_rdy_o) begin
               state_d = IDLE;
               ptr_d   = ptr_nxt;
               gnt_d   = '0;
               idx_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
      end

   assign grant_o     = gnt_q;
   assign grant_idx_o = idx_q;
   assign grant_vld_o = state_q != IDLE;

endmodule

// File: tb/tb_liteic_slave_arbiter.sv
// tb_liteic_slave_arbiter: directed checks of two arbiters (full and 3'b101 connectivity) against a cycle model
module tb_liteic_slave_arbiter;

   logic       clk = 1'b0;
   logic       rstn;
   logic [2:0] val [2];
   logic [2:0] rrdy [2];
   logic [2:0] rdy [2];
   logic [2:0] gnt [2];
   logic [2:0] rv [2];
   logic [1:0] gidx [2];
   logic [1:0] srdy, srv, srv_man, auto_rsp, gv, sval, srr;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int m_ph [2] = '{0, 0};
   int m_g [2] = '{0, 0};
   int m_ptr [2] = '{0, 0};
   int m_age [2] = '{0, 0};
   int q_idx [$];
   int q_cyc [$];
   logic gv0_d = 1'b0;

   always #5 clk = ~clk;

   task automatic chk(input string n, input int k, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%0h want=%0h", n, k, act, exp);
      end
   endtask

   // First eligible master at or after p, ascending with wrap over three masters.
   function automatic int pick(input logic [2:0] v, input int p);
      for (int o = 0; o < 3; o++)
         if (v[(p + o) % 3]) return (p + o) % 3;
      return 0;
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g_dut
      localparam logic [2:0] M = (k == 0) ? 3'b111 : 3'b101;

      liteic_slave_arbiter #(.NUM_MST(3), .CONN_MASK(M)) u_dut (
         .clk_i           (clk),
         .rstn_i          (rstn),
         .reqst_val_i     (val[k]),
         .reqst_rdy_o     (rdy[k]),
         .grant_o         (gnt[k]),
         .grant_idx_o     (gidx[k]),
         .grant_vld_o     (gv[k]),
         .slv_reqst_val_o (sval[k]),
         .slv_reqst_rdy_i (srdy[k]),
         .slv_resp_val_i  (srv[k]),
         .slv_resp_rdy_o  (srr[k]),
         .resp_val_o      (rv[k]),
         .resp_rdy_i      (rrdy[k])
      );

      // Automatic slave answers one cycle after the transaction enters its response phase.
      assign srv[k] = auto_rsp[k] ? (m_ph[k] == 2 && m_age[k] >= 1) : srv_man[k];

      always @(posedge clk or negedge rstn)
         if (!rstn) begin
            m_ph[k]  <= 0;
            m_g[k]   <= 0;
            m_ptr[k] <= 0;
            m_age[k] <= 0;
         end else begin
            m_age[k] <= (m_ph[k] == 2) ? m_age[k] + 1 : 0;
            if (m_ph[k] == 0 && (val[k] & M) != 3'b000) begin
               m_g[k]  <= pick(val[k] & M, m_ptr[k]);
               m_ph[k] <= 1;
            end else if (m_ph[k] == 1 && val[k][m_g[k]] && srdy[k]) begin
               m_ph[k] <= 2;
            end else if (m_ph[k] == 2 && srv[k] && rrdy[k][m_g[k]]) begin
               m_ph[k]  <= 0;
               m_ptr[k] <= (m_g[k] + 1) % 3;
            end
         end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      gv0_d <= gv[0];
      if (gv[0] && !gv0_d) begin
         q_idx.push_back(int'(gidx[0]));
         q_cyc.push_back(cyc);
      end
   end

   always @(negedge clk) begin
      logic a, r;
      logic [2:0] oh;
      for (int k = 0; k < 2; k++) begin
         a  = rstn && m_ph[k] == 1;
         r  = rstn && m_ph[k] == 2;
         oh = 3'b001 << m_g[k];
         chk("grant", k, gnt[k], (a || r) ? oh : 3'b000);
         chk("grant_vld", k, gv[k], a || r);
         if (a || r) chk("grant_idx", k, gidx[k], m_g[k]);
         chk("slv_reqst_val", k, sval[k], a && val[k][m_g[k]]);
         chk("reqst_rdy", k, rdy[k], (a && srdy[k]) ? oh : 3'b000);
         chk("slv_resp_rdy", k, srr[k], r && rrdy[k][m_g[k]]);
         chk("resp_val", k, rv[k], (r && srv[k]) ? oh : 3'b000);
      end
   end

   initial begin
      int hits;
      bit found;
      rstn     = 1'b0;
      val      = '{3'b000, 3'b000};
      rrdy     = '{3'b111, 3'b000};
      srdy     = 2'b01;
      srv_man  = 2'b00;
      auto_rsp = 2'b01;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_grant", 0, gnt[0], 3'b000);
      chk("reset_vld", 0, gv[0], 1'b0);
      @(posedge clk);
      #1 rstn = 1'b1;
      val[0] = 3'b111;
      repeat (16) @(posedge clk);
      #1 val[0] = 3'b000;
      chk("rr_count", 0, q_idx.size(), 4);
      chk("rr_first", 0, q_idx[0], 0);
      chk("rr_second", 0, q_idx[1], 1);
      chk("rr_third", 0, q_idx[2], 2);
      chk("rr_fourth", 0, q_idx[3], 0);
      chk("rr_period", 0, q_cyc[3] - q_cyc[0], 12);
      q_idx.delete();
      q_cyc.delete();
      val[0] = 3'b010;
      repeat (4) @(posedge clk);
      #1 val[0] = 3'b101;
      repeat (8) @(posedge clk);
      #1 val[0] = 3'b000;
      chk("wrap_count", 0, q_idx.size(), 3);
      chk("wrap_m2", 0, q_idx[1], 2);
      chk("wrap_m0", 0, q_idx[2], 0);
      srdy[1] = 1'b1;
      val[1]  = 3'b010;
      hits    = 0;
      repeat (100) begin
         @(negedge clk);
         if (gv[1] || rdy[1] != 3'b000 || sval[1]) hits++;
      end
      chk("masked_quiet", 1, hits, 0);
      @(posedge clk);
      #1 srdy[1] = 1'b0;
      val[1] = 3'b110;
      @(posedge clk);
      @(negedge clk);
      chk("masked_grant", 1, gnt[1], 3'b100);
      repeat (5) begin
         @(negedge clk);
         chk("stall_grant", 1, gnt[1], 3'b100);
         chk("stall_rdy", 1, rdy[1], 3'b000);
         chk("stall_vld", 1, gv[1], 1'b1);
      end
      @(posedge clk);
      #1 srdy[1] = 1'b1;
      @(negedge clk);
      chk("addr_rdy", 1, rdy[1], 3'b100);
      chk("addr_val", 1, sval[1], 1'b1);
      @(posedge clk);
      #1 srv_man[1] = 1'b1;
      rrdy[1] = 3'b011;
      repeat (3) begin
         @(negedge clk);
         chk("resp_hold_rdy", 1, srr[1], 1'b0);
         chk("resp_hold_val", 1, rv[1], 3'b100);
      end
      @(posedge clk);
      #1 rrdy[1] = 3'b111;
      @(negedge clk);
      chk("resp_done_rdy", 1, srr[1], 1'b1);
      @(posedge clk);
      #1 srv_man[1] = 1'b0;
      val[1]  = 3'b000;
      srdy[1] = 1'b0;
      @(negedge clk);
      chk("resp_back_idle", 1, gv[1], 1'b0);
      val[0] = 3'b111;
      found  = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         found = srr[0];
      end
      chk("wait_resp", 0, found, 1'b1);
      #1 rstn = 1'b0;
      #1;
      chk("rst_vld", 0, gv[0], 1'b0);
      chk("rst_grant", 0, gnt[0], 3'b000);
      chk("rst_resp_rdy", 0, srr[0], 1'b0);
      chk("rst_resp_val", 0, rv[0], 3'b000);
      chk("rst_reqst_rdy", 0, rdy[0], 3'b000);
      chk("rst_slv_val", 0, sval[0], 1'b0);
      @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_first_m0", 0, gnt[0], 3'b001);
      repeat (3) @(posedge clk);
      #1 val[0] = 3'b000;
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/liteic_slave_arbiter.md
LITEIC_SLAVE_ARBITER -- requirements
Module: liteic_slave_arbiter

Interface
REQ-001 Parameter NUM_MST, default IC_NUM_MASTER_SLOTS: number of master requesters sharing one slave node channel (read AR or write AW).
REQ-002 Parameter CONN_MASK [NUM_MST-1:0], default all ones: bit i=1 means master i may reach this slave (connectivity column).
REQ-003 clk_i  in  1  sole clock, rising edge.
REQ-004 rstn_i  in  1  asynchronous, active-low reset.
REQ-005 reqst_val_i  in  NUM_MST  per-master request valid from crossbar.
REQ-006 reqst_rdy_o  out  NUM_MST  per-master request ready; at most one bit set.
REQ-007 grant_o  out  NUM_MST  one-hot registered grant, data-mux select.
REQ-008 grant_idx_o  out  clog2(NUM_MST) (min 1)  binary index of grant_o.
REQ-009 grant_vld_o  out  1  a grant is held.
REQ-010 slv_reqst_val_o  out  1  request valid toward slave port.
REQ-011 slv_reqst_rdy_i  in  1  slave port request ready.
REQ-012 slv_resp_val_i  in  1  slave port response valid.
REQ-013 slv_resp_rdy_o  out  1  response ready toward slave port.
REQ-014 resp_val_o  out  NUM_MST  per-master response valid, one-hot.
REQ-015 resp_rdy_i  in  NUM_MST  per-master response ready.

Function
REQ-016 States: IDLE, ADDR, RESP; one outstanding transaction per slave.
REQ-017 Eligible requests = reqst_val_i & CONN_MASK; masked masters never granted, their reqst_rdy_o and resp_val_o stay 0.
REQ-018 IDLE: any eligible request -> register round-robin winner into grant_o/grant_idx_o, go ADDR next cycle; none -> stay IDLE.
REQ-019 Round-robin: search starts at pointer ptr, ascending index, wraps NUM_MST-1 -> 0; first eligible wins.
REQ-020 ADDR: slv_reqst_val_o = reqst_val_i[grant_idx_o]; reqst_rdy_o[grant_idx_o] = slv_reqst_rdy_i; other bits 0.
REQ-021 ADDR: handshake (slv_reqst_val_o & slv_reqst_rdy_i) -> RESP; otherwise stay ADDR, grant held even if granted master drops valid.
REQ-022 RESP: resp_val_o = grant_o when slv_resp_val_i, else 0; slv_resp_rdy_o = resp_rdy_i[grant_idx_o].
REQ-023 RESP: response handshake -> IDLE, ptr <= grant_idx_o+1 (wrap to 0 past NUM_MST-1); grant_o cleared.
REQ-024 Grant latency: request in IDLE cycle N -> slv_reqst_val_o high cycle N+1; minimum transaction 3 cycles, one IDLE bubble between back-to-back transactions.
REQ-025 Request and response never in the same transaction cycle; slv_resp_val_i outside RESP is ignored, slv_resp_rdy_o=0.
REQ-026 In IDLE: slv_reqst_val_o, slv_resp_rdy_o, reqst_rdy_o, resp_val_o, grant_o, grant_vld_o all 0.
REQ-027 grant_vld_o = 1 in ADDR and RESP only.
REQ-028 NUM_MST=1: ptr constant 0, arbitration degenerates to pass-through with the same FSM timing.

Reset
REQ-029 rstn_i low, any state: immediately state=IDLE, ptr=0, grant_o=0, grant_idx_o=0; all outputs 0.
REQ-030 Reset mid-transaction abandons it; no response is forwarded after deassertion.
REQ-031 First eligible request after reset favors lowest index.

Structure
REQ-032 arb_state_t (IDLE/ADDR/RESP) typedef lives in liteic_pkg beside IC_NUM_MASTER_SLOTS and connectivity constants.
REQ-033 Combinational round-robin search is sub-module liteic_rr_picker (inputs req, ptr; outputs one-hot, index, any).
REQ-034 One instance per slave node per channel (read, write); CONN_MASK driven from the matching connectivity column.

Verification
REQ-035 NUM_MST=3, masters 0,1,2 request continuously, slave always ready, resp 1 cycle later -> grant order 0,1,2,0; 4 cycles per transaction.
REQ-036 CONN_MASK=3'b101, only master 1 requests -> no grant, reqst_rdy_o=0 for 100 cycles; master 2 then requests -> granted next cycle.
REQ-037 Master 2 granted, slv_reqst_rdy_i low 5 cycles -> state ADDR held, grant_o=3'b100 stable, reqst_rdy_o=0 until ready.
REQ-038 RESP with resp_rdy_i[granted]=0 for 3 cycles -> slv_resp_rdy_o=0, resp_val_o held one-hot; completes on first ready.
REQ-039 ptr=2, masters 0 and 2 request -> master 2 granted, then ptr wraps to 0, master 0 granted next.
REQ-040 rstn_i low during RESP -> outputs 0 same cycle; after release master 0 wins among all requesters.
